// File: rtl/mf_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : mf_clken_gen
// Purpose  : Runtime-programmable fractional clock-enable generator. Runs on
//            the fast PLL clock and produces NUM_CHANNELS single-cycle enable
//            pulses. Each channel has its own num/den ratio and phase offset.
//            Pulses are generated only after the PLL has held lock for
//            LOCK_CYCLES consecutive cycles.
// Ports    : refclk      in   fast clock, all logic on its rising edge
//            rst         in   asynchronous active-high reset
//            pll_locked  in   raw PLL lock flag (2-flop synchronised here)
//            cfg_we      in   one-cycle config write strobe
//            cfg_ch      in   channel index for the write
//            cfg_num     in   ratio numerator
//            cfg_den     in   ratio denominator (0 disables the channel)
//            cfg_phase   in   accumulator start value (phase offset)
//            resync      in   reload every accumulator from its phase (RUN)
//            clken       out  per-channel enable pulses, registered
//            locked      out  high while running, registered
// Revision : 1.0  initial release
// ============================================================================
module mf_clken_gen #(
    parameter int NUM_CHANNELS = 4,
    parameter int ACC_WIDTH    = 16,
    parameter int LOCK_CYCLES  = 256,
    parameter int DEFAULT_NUM  = 1,
    parameter int DEFAULT_DEN  = 16,
    localparam int c_ch_w      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic                    cfg_we,
    input  logic [c_ch_w-1:0]       cfg_ch,
    input  logic [ACC_WIDTH-1:0]    cfg_num,
    input  logic [ACC_WIDTH-1:0]    cfg_den,
    input  logic [ACC_WIDTH-1:0]    cfg_phase,
    input  logic                    resync,
    output logic [NUM_CHANNELS-1:0] clken,
    output logic                    locked
);

    localparam int       c_cnt_w        = $clog2(LOCK_CYCLES + 1);
    localparam logic [0:0] c_st_wait_lock = 1'b0;
    localparam logic [0:0] c_st_run       = 1'b1;

    logic               r_lock_meta;
    logic               r_lock_sync;
    logic [0:0]         r_state;
    logic [c_cnt_w-1:0] r_lock_cnt;
    logic               r_locked;

    logic w_lock_edge;     // the edge on which WAIT_LOCK hands over to RUN
    logic w_run_step;      // channels advance on this edge
    logic w_resync_load;   // resync honoured (only while running and locked)

    assign w_lock_edge   = (r_state == c_st_wait_lock) && r_lock_sync &&
                           (r_lock_cnt == c_cnt_w'(LOCK_CYCLES - 1));
    assign w_run_step    = (r_state == c_st_run) && r_lock_sync;
    assign w_resync_load = w_run_step && resync;

    // ------------------------------------------------------------------------
    // Lock qualification FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_state     <= c_st_wait_lock;
            r_lock_cnt  <= '0;
            r_locked    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
            case (r_state)
                c_st_wait_lock: begin
                    if (r_lock_sync) begin
                        if (w_lock_edge) begin
                            r_state    <= c_st_run;
                            r_lock_cnt <= '0;
                            r_locked   <= 1'b1;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + c_cnt_w'(1);
                        end
                    end else begin
                        // Lock must be held for consecutive cycles
                        r_lock_cnt <= '0;
                    end
                end
                c_st_run: begin
                    if (!r_lock_sync) begin
                        r_state    <= c_st_wait_lock;
                        r_lock_cnt <= '0;
                        r_locked   <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= c_st_wait_lock;
                    r_lock_cnt <= '0;
                    r_locked   <= 1'b0;
                end
            endcase
        end
    end

    assign locked = r_locked;

    // ------------------------------------------------------------------------
    // Per-channel fractional accumulators
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
            logic [ACC_WIDTH-1:0] r_num;
            logic [ACC_WIDTH-1:0] r_den;
            logic [ACC_WIDTH-1:0] r_phase;
            logic [ACC_WIDTH-1:0] r_acc;
            logic                 r_clken;

            logic                 w_sel;
            logic                 w_load;
            logic                 w_hit;
            logic [ACC_WIDTH-1:0] w_den_n;
            logic [ACC_WIDTH-1:0] w_phase_n;
            logic [ACC_WIDTH-1:0] w_load_val;
            logic [ACC_WIDTH-1:0] w_num_eff;
            logic [ACC_WIDTH-1:0] w_acc_step;
            logic [ACC_WIDTH:0]   w_sum;

            // An out-of-range cfg_ch matches no channel, so it is ignored.
            assign w_sel     = cfg_we && (cfg_ch == c_ch_w'(gi));
            assign w_load    = w_sel || w_lock_edge || w_resync_load;

            // Loads always use the configuration being written this edge.
            assign w_den_n   = w_sel ? cfg_den   : r_den;
            assign w_phase_n = w_sel ? cfg_phase : r_phase;

            // Clamp the start value below den so the accumulator invariant
            // acc < den holds from the first step.
            always_comb begin
                w_load_val = w_phase_n;
                if (w_den_n == '0) begin
                    w_load_val = '0;
                end else if (w_phase_n >= w_den_n) begin
                    w_load_val = w_den_n - ACC_WIDTH'(1);
                end
            end

            // num above den behaves as num == den (pulse every cycle).
            assign w_num_eff  = (r_num > r_den) ? r_den : r_num;
            // One extra bit so acc + num cannot wrap for large dens.
            assign w_sum      = {1'b0, r_acc} + {1'b0, w_num_eff};
            assign w_hit      = (w_sum >= {1'b0, r_den});
            // True difference is below den, so the low bits are exact.
            assign w_acc_step = w_sum[ACC_WIDTH-1:0] - r_den;

            always_ff @(posedge refclk or posedge rst) begin
                if (rst) begin
                    r_num   <= ACC_WIDTH'(DEFAULT_NUM);
                    r_den   <= ACC_WIDTH'(DEFAULT_DEN);
                    r_phase <= '0;
                    r_acc   <= '0;
                    r_clken <= 1'b0;
                end else begin
                    if (w_sel) begin
                        r_num   <= cfg_num;
                        r_den   <= cfg_den;
                        r_phase <= cfg_phase;
                    end
                    if (w_load) begin
                        r_acc   <= w_load_val;
                        r_clken <= 1'b0;
                    end else if (w_run_step && (r_den != '0)) begin
                        r_acc   <= w_hit ? w_acc_step : w_sum[ACC_WIDTH-1:0];
                        r_clken <= w_hit;
                    end else begin
                        // Waiting for lock, leaving RUN, or channel disabled
                        r_clken <= 1'b0;
                    end
                end
            end

            assign clken[gi] = r_clken;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mf_clken_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mf_clken_gen
// Purpose  : Self-checking bench for mf_clken_gen. Drives a 4-channel and a
//            3-channel instance with identical stimulus; a reference model
//            predicts each edge's outputs into a queue that a monitor drains.
//            The model derives pulses from floor((phase + k*num)/den).
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_mf_clken_gen;

    localparam int c_lock = 32;

    logic        refclk = 1'b0;
    logic        rst;
    logic        pll_locked;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_num;
    logic [15:0] cfg_den;
    logic [15:0] cfg_phase;
    logic        resync;
    logic [3:0]  clken4;
    logic        locked4;
    logic [2:0]  clken3;
    logic        locked3;

    always #5 refclk = ~refclk;

    mf_clken_gen #(.NUM_CHANNELS(4), .ACC_WIDTH(16), .LOCK_CYCLES(c_lock),
                   .DEFAULT_NUM(1), .DEFAULT_DEN(16)) u_dut4 (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_num(cfg_num), .cfg_den(cfg_den),
        .cfg_phase(cfg_phase), .resync(resync), .clken(clken4), .locked(locked4));

    mf_clken_gen #(.NUM_CHANNELS(3), .ACC_WIDTH(16), .LOCK_CYCLES(c_lock),
                   .DEFAULT_NUM(1), .DEFAULT_DEN(16)) u_dut3 (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_num(cfg_num), .cfg_den(cfg_den),
        .cfg_phase(cfg_phase), .resync(resync), .clken(clken3), .locked(locked3));

    typedef struct packed {
        logic [3:0] c4;
        logic       l4;
        logic [2:0] c3;
        logic       l3;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: [instance][channel]
    bit     m_d1, m_d2, m_run;
    int     m_cnt;
    longint m_num[2][4], m_den[2][4], m_ph[2][4], m_p[2][4], m_k[2][4];
    bit     cur_pll;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic void m_load(input int d, input int c);
        if (m_den[d][c] == 0)               m_p[d][c] = 0;
        else if (m_ph[d][c] >= m_den[d][c]) m_p[d][c] = m_den[d][c] - 1;
        else                                m_p[d][c] = m_ph[d][c];
        m_k[d][c] = 0;
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                m_num[d][c] = 1; m_den[d][c] = 16; m_ph[d][c] = 0;
                m_p[d][c] = 0;   m_k[d][c] = 0;
            end
        m_d1 = 0; m_d2 = 0; m_run = 0; m_cnt = 0;
    endfunction

    // Drive one edge's inputs, predict that edge's outputs, return after it.
    task automatic step(input bit r, input bit p, input bit we, input int ch,
                        input int n, input int dn, input int ph, input bit rs);
        exp_t   e;
        bit     sync, b;
        longint ne, dd, pp, kk;
        @(negedge refclk);
        rst = r; pll_locked = p; cfg_we = we; cfg_ch = 2'(ch);
        cfg_num = 16'(n); cfg_den = 16'(dn); cfg_phase = 16'(ph); resync = rs;
        e = '0;
        if (r) begin
            m_reset();
        end else begin
            sync = m_d2; m_d2 = m_d1; m_d1 = p;
            for (int d = 0; d < 2; d++)
                if (we && ch < nch(d)) begin
                    m_num[d][ch] = n; m_den[d][ch] = dn; m_ph[d][ch] = ph;
                end
            if (!m_run) begin
                if (we)
                    for (int d = 0; d < 2; d++) if (ch < nch(d)) m_load(d, ch);
                if (sync) begin
                    m_cnt++;
                    if (m_cnt == c_lock) begin
                        m_run = 1; m_cnt = 0;
                        for (int d = 0; d < 2; d++)
                            for (int c = 0; c < nch(d); c++) m_load(d, c);
                    end
                end else begin
                    m_cnt = 0;
                end
            end else if (!sync) begin
                m_run = 0; m_cnt = 0;
            end else begin
                for (int d = 0; d < 2; d++)
                    for (int c = 0; c < nch(d); c++) begin
                        b = 0;
                        if (rs || (we && ch == c)) begin
                            m_load(d, c);
                        end else if (m_den[d][c] != 0) begin
                            m_k[d][c]++;
                            dd = m_den[d][c];
                            ne = (m_num[d][c] > dd) ? dd : m_num[d][c];
                            pp = m_p[d][c]; kk = m_k[d][c];
                            b  = ((pp + kk * ne) / dd) != ((pp + (kk - 1) * ne) / dd);
                        end
                        if (d == 0) e.c4[c] = b; else e.c3[c] = b;
                    end
            end
            e.l4 = m_run; e.l3 = m_run;
        end
        exp_q.push_back(e);
        @(posedge refclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, cur_pll, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input int n, input int dn, input int ph);
        step(0, cur_pll, 1, ch, n, dn, ph, 0);
    endtask

    task automatic async_reset_check();
        @(negedge refclk);
        rst = 1'b1;
        #1;
        check("rst_locked4", 32'(locked4), 32'd0);
        check("rst_clken4", 32'(clken4), 32'd0);
        check("rst_clken3", 32'(clken3), 32'd0);
    endtask

    // Monitor: one expected entry per active edge
    initial begin : p_monitor
        exp_t e;
        forever begin
            @(posedge refclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("clken4", 32'(clken4), 32'(e.c4));
                check("locked4", 32'(locked4), 32'(e.l4));
                check("clken3", 32'(clken3), 32'(e.c3));
                check("locked3", 32'(locked3), 32'(e.l3));
            end
        end
    end

    initial begin : p_watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int lat, first, f0, f1, cnt2, np, i, c3, c2, c1, drop;
        int pulses[4];
        logic [3:0] snap;
        bit found;

        rst = 1; pll_locked = 0; cfg_we = 0; cfg_ch = 0;
        cfg_num = 0; cfg_den = 0; cfg_phase = 0; resync = 0;
        cur_pll = 0;
        m_reset();
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);

        // Lock qualification latency with pll_locked held high
        cur_pll = 1; found = 0; lat = 0;
        for (int k = 1; k <= c_lock + 20 && !found; k++) begin
            idle(1);
            if (locked4) begin found = 1; lat = k; end
        end
        check("lock_latency", 32'(lat), 32'(c_lock + 2));

        // Default 1/16: all channels pulse together on edge 16
        first = 0; snap = '0;
        for (int k = 1; k <= 40; k++) begin
            idle(1);
            if (clken4[0] && first == 0) begin first = k; snap = clken4; end
        end
        check("first_pulse", 32'(first), 32'd16);
        check("first_pulse_all", 32'(snap), 32'hf);

        // Phase offset on ch1, 3/16 on ch2, then realign everything
        wr(1, 1, 16, 8);
        wr(2, 3, 16, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1);
        f0 = 0; f1 = 0; cnt2 = 0; np = 0;
        for (int k = 1; k <= 1600; k++) begin
            idle(1);
            if (clken4[0] && f0 == 0) f0 = k;
            if (clken4[1] && f1 == 0) f1 = k;
            if (clken4[2]) begin
                cnt2++;
                if (np < 4) begin pulses[np] = k; np++; end
            end
        end
        check("ch0_first", 32'(f0), 32'd16);
        check("ch1_first", 32'(f1), 32'd8);
        check("ch2_count", 32'(cnt2), 32'd300);
        check("ch2_gap0", 32'(pulses[1] - pulses[0]), 32'd5);
        check("ch2_gap1", 32'(pulses[2] - pulses[1]), 32'd5);
        check("ch2_gap2", 32'(pulses[3] - pulses[2]), 32'd6);

        // One-cycle lock loss
        step(0, 0, 0, 0, 0, 0, 0, 0);
        i = 1;
        while (locked4 && i < 6) begin idle(1); i++; end
        check("unlock_within_3", 32'(i <= 3), 32'd1);
        check("unlock_clken", 32'(clken4), 32'd0);
        found = 0;
        for (int k = 0; k < c_lock + 10 && !found; k++) begin
            idle(1);
            if (locked4) found = 1;
        end
        check("relock", 32'(found), 32'd1);
        idle(40);

        // Edge cases: num=den, num>den, den=0, phase>=den (ch3 absent in 3-ch)
        wr(3, 5, 5, 0);
        wr(2, 9, 4, 0);
        wr(1, 1, 0, 0);
        wr(0, 1, 16, 20);
        c3 = 0; c2 = 0; c1 = 0; first = 0;
        for (int k = 1; k <= 32; k++) begin
            idle(1);
            if (k == 1) first = int'(clken4[0]);
            c3 += int'(clken4[3]);
            c2 += int'(clken4[2]);
            c1 += int'(clken4[1]);
        end
        check("num_eq_den", 32'(c3), 32'd32);
        check("num_gt_den", 32'(c2), 32'd32);
        check("den_zero", 32'(c1), 32'd0);
        check("phase_clamp", 32'(first), 32'd1);
        wr(0, 40000, 60000, 59999);
        idle(20);

        // resync together with a write to ch3
        step(0, 1, 1, 3, 2, 8, 1, 1);
        check("resync_clken4", 32'(clken4), 32'd0);
        check("resync_clken3", 32'(clken3), 32'd0);
        idle(40);

        // Randomised traffic with occasional lock drops and one async reset
        drop = 0;
        for (int k = 0; k < 3000; k++) begin
            bit p, we, rs;
            int ch, n, dn, ph;
            if (k == 1500) begin
                async_reset_check();
                repeat (2) step(1, 1, 0, 0, 0, 0, 0, 0);
            end
            if (drop > 0) begin p = 0; drop--; end
            else begin
                p = 1;
                if ($urandom % 400 == 0) drop = int'($urandom_range(1, 3));
            end
            we = ($urandom % 16) == 0;
            ch = int'($urandom % 4);
            dn = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 20));
            n  = int'($urandom_range(0, 24));
            ph = int'($urandom_range(0, 24));
            rs = ($urandom % 60) == 0;
            step(0, p, we, ch, n, dn, ph, rs);
        end

        idle(2);
        repeat (2) @(posedge refclk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
